video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 110, 40, 220, horizontal front porch, sync and back porch in pixels; H_TOTAL = sum of all four = 1650.
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 720, 5, 5, 20, in lines; V_TOTAL = 750.
REQ-004 SHALL have parameter DATA_LAT, default 2, legal range 1..8, cycles from video_de to the returned pixel on lcd_*.
REQ-005 SHALL have parameters HS_POL and VS_POL, default 1 each; 1 means lcd_hs/lcd_vs are active-high.
REQ-006 SHALL have port clk, input, 1, pixel clock; the only clock.
REQ-007 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-008 SHALL have port en, input, 1, timing run enable.
REQ-009 SHALL have ports video_de, video_hs, video_vs, output, 1 each, active-high request timing to the frame buffer read side.
REQ-010 SHALL have ports pix_x and pix_y, output, 12 each, active-area coordinates.
REQ-011 SHALL have port frame_start, output, 1, one-cycle pulse at the first pixel of each frame.
REQ-012 SHALL have ports in_r (5), in_g (6), in_b (5), input, pixel data returned by the frame buffer.
REQ-013 SHALL have ports lcd_de, lcd_hs, lcd_vs (1 each) and lcd_r (5), lcd_g (6), lcd_b (5), output, aligned panel stream.
REQ-014 SHALL have port test_sel, input, 1, colour-bar select (see Configuration).

Function
REQ-015 h_cnt SHALL count 0..H_TOTAL-1, +1 per clk while en=1, then wrap to 0; v_cnt SHALL increment on each h_cnt wrap and wrap to 0 after V_TOTAL-1.
REQ-016 Counter order SHALL be active, front porch, sync, back porch: h_cnt=0 is the first active pixel, and v_cnt=0 is the first active line.
REQ-017 video_de SHALL equal (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE), registered: 1 clk latency from the counter.
REQ-018 video_hs SHALL be 1 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; video_vs SHALL be 1 for whole lines v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; both registered with the same latency as video_de.
REQ-019 pix_x/pix_y SHALL equal h_cnt/v_cnt when video_de=1, else 0, on the same cycle as video_de.
REQ-020 frame_start SHALL be 1 for exactly one cycle, on the same cycle as video_de for h_cnt=0, v_cnt=0.
REQ-021 lcd_de/lcd_hs/lcd_vs SHALL equal video_de/video_hs/video_vs delayed DATA_LAT clk through a shift register; lcd_hs is inverted when HS_POL=0, and lcd_vs is inverted when VS_POL=0.
REQ-022 lcd_r/g/b SHALL be in_r/g/b registered once, captured on the cycle where the delayed de reaches stage DATA_LAT-1; they SHALL be forced to 0 when lcd_de=0.
REQ-023 en=0 SHALL synchronously clear h_cnt and v_cnt to 0 and force video_de/hs/vs and frame_start to 0 on the next cycle; the lcd pipeline SHALL keep shifting and drain to inactive.
REQ-024 en 0->1 SHALL start a fresh frame: frame_start on the 2nd clk edge after en rises.
REQ-025 On a simultaneous h_cnt and v_cnt wrap, both SHALL return to 0 on the same edge, with no extra line.

Reset
REQ-026 rst_n=0 sampled on clk SHALL clear counters and the shift register, and drive every output to 0; lcd_hs/lcd_vs SHALL go to their inactive level (0 if POL=1, 1 if POL=0).
REQ-027 Reset asserted mid-line or mid-frame SHALL abort the frame; after release, timing restarts from h_cnt=0, v_cnt=0.

Configuration
REQ-028 With macro VTG_TEST_PATTERN_EN defined and test_sel=1, lcd_r/g/b SHALL be 8 vertical bars, each H_ACTIVE/8 (=160) pixels wide, keyed on pix_x delayed with lcd_de, in the order white, yellow, cyan, green, magenta, red, blue, black; in_* SHALL be ignored and timing SHALL be unchanged.
REQ-029 Without VTG_TEST_PATTERN_EN, test_sel SHALL be ignored and no bar logic SHALL be synthesized.

Verification
REQ-030 Default parameters, en=1 for 2 frames -> video_de high for 1280 consecutive clk per line, 720 lines per frame; period 1650x750=1,237,500 clk between frame_start pulses.
REQ-031 Default parameters -> video_hs high for 40 clk starting 1390 clk after the line's first de; video_vs high for 5 lines starting at v_cnt=725.
REQ-032 DATA_LAT=3, in_* = pix_x-derived ramp returned 2 clk after video_de -> lcd_de 3 clk after video_de, lcd_r/g/b match the ramp pixel-exact, and are 0 in blanking.
REQ-033 en dropped at h_cnt=500, v_cnt=100 for 10 clk, then raised -> video_de=0 for the gap, frame_start 2 clk after en rises, pix_x restarts at 0.
REQ-034 rst_n pulsed low for 1 clk mid-frame with HS_POL=0 -> all outputs 0 and lcd_hs=1 on the next cycle; normal timing resumes from (0,0).
REQ-035 VTG_TEST_PATTERN_EN defined, test_sel=1 -> lcd pixel 0 = 5'h1F/6'h3F/5'h1F, pixel 160 = yellow, pixel 1279 = 0.

Source files
------------

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Free-running raster timing generator for an RGB565 panel. It produces
//   frame-buffer read requests (video_de/hs/vs, pix_x/pix_y, frame_start),
//   then realigns the returned pixel data with a DATA_LAT-deep copy of the
//   timing to form the lcd_* stream.
//
//   Horizontal and vertical counters run in the order active, front porch,
//   sync, back porch, so counter value 0 is the first active pixel/line.
//
//   Optional build macro: VTG_TEST_PATTERN_EN
//     When defined, test_sel=1 replaces the returned pixel data with eight
//     vertical colour bars keyed on the delayed pixel column. When undefined,
//     test_sel is ignored and no bar logic exists.
// -----------------------------------------------------------------------------
module video_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter int DATA_LAT = 2,
   parameter int HS_POL   = 1,
   parameter int VS_POL   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        video_de,
   output logic        video_hs,
   output logic        video_vs,
   output logic [11:0] pix_x,
   output logic [11:0] pix_y,
   output logic        frame_start,
   input  logic [4:0]  in_r,
   input  logic [5:0]  in_g,
   input  logic [4:0]  in_b,
   output logic        lcd_de,
   output logic        lcd_hs,
   output logic        lcd_vs,
   output logic [4:0]  lcd_r,
   output logic [5:0]  lcd_g,
   output logic [4:0]  lcd_b,
   input  logic        test_sel
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic        HS_INV   = (HS_POL == 0);
   localparam logic        VS_INV   = (VS_POL == 0);

   logic [11:0] h_cnt;
   logic [11:0] v_cnt;
   logic        en_d;
   logic        run;
   logic        h_wrap;
   logic        v_wrap;
   logic        active;

   // Counting starts only once en has been high for a full cycle, so a rising
   // en always begins from the cleared (0,0) position with one idle edge.
   assign run    = en & en_d;
   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);
   assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

   // Raster position counters; both wrap on the same edge at end of frame.
   // NOTE: reset here is synchronous - rst_n is only looked at on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_d  <= 1'b0;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         // NOTE: state updates use <= so every register sees pre-edge values.
         en_d <= en;
         if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
         end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
         end else begin
            h_cnt <= h_cnt + 12'd1;
         end
      end
   end

   // Registered request timing, one clock behind the counters.
   always_ff @(posedge clk) begin
      if (!rst_n || !run) begin
         video_de    <= 1'b0;
         video_hs    <= 1'b0;
         video_vs    <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
      end else begin
         video_de    <= active;
         video_hs    <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
         video_vs    <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
         pix_x       <= active ? h_cnt : 12'd0;
         pix_y       <= active ? v_cnt : 12'd0;
         frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
      end
   end

   logic [DATA_LAT-1:0] de_sr;
   logic [DATA_LAT-1:0] hs_sr;
   logic [DATA_LAT-1:0] vs_sr;

   // Timing delay line; keeps shifting while en is low so it drains to idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         de_sr <= '0;
         hs_sr <= '0;
         vs_sr <= '0;
      end else begin
         de_sr[0] <= video_de;
         hs_sr[0] <= video_hs;
         vs_sr[0] <= video_vs;
         for (int i = 1; i < DATA_LAT; i++) begin
            de_sr[i] <= de_sr[i-1];
            hs_sr[i] <= hs_sr[i-1];
            vs_sr[i] <= vs_sr[i-1];
         end
      end
   end

   // de as it enters the last delay stage: marks the cycle the frame buffer
   // presents the pixel that lcd_de will qualify on the next cycle.
   logic de_pre;
   if (DATA_LAT == 1) begin : g_pre_lat1
      assign de_pre = video_de;
   end else begin : g_pre_latn
      assign de_pre = de_sr[DATA_LAT-2];
   end

   logic [15:0] src_rgb;

`ifdef VTG_TEST_PATTERN_EN
   localparam int          BAR_W  = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   localparam logic [11:0] BAR_WL = 12'(BAR_W);

   logic [11:0] x_pre;
   logic [11:0] bar_q;
   logic [2:0]  bar_idx;
   logic [15:0] bar_rgb;

   if (DATA_LAT == 1) begin : g_x_lat1
      assign x_pre = pix_x;
   end else begin : g_x_latn
      logic [11:0] x_sr [DATA_LAT-1];
      // Column delay line matching de_pre; qualified by de, so no reset needed.
      // NOTE: pure data pipelines are left unreset; de/reset gating covers them.
      always_ff @(posedge clk) begin
         x_sr[0] <= pix_x;
         for (int i = 1; i < DATA_LAT - 1; i++) begin
            x_sr[i] <= x_sr[i-1];
         end
      end
      assign x_pre = x_sr[DATA_LAT-2];
   end

   // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to
   // r = ~idx[1], g = ~idx[2], b = ~idx[0]; columns past the 8th bar stay black.
   assign bar_q   = x_pre / BAR_WL;
   assign bar_idx = (bar_q > 12'd7) ? 3'd7 : bar_q[2:0];
   assign bar_rgb = {{5{~bar_idx[1]}}, {6{~bar_idx[2]}}, {5{~bar_idx[0]}}};
   assign src_rgb = test_sel ? bar_rgb : {in_r, in_g, in_b};
`else
   logic unused_test_sel;
   assign unused_test_sel = test_sel;
   assign src_rgb         = {in_r, in_g, in_b};
`endif

   logic [15:0] rgb_q;

   // Pixel capture register; blanking forces black so lcd_rgb is 0 when !lcd_de.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= de_pre ? src_rgb : 16'd0;
      end
   end

   assign lcd_de = de_sr[DATA_LAT-1];
   assign lcd_hs = hs_sr[DATA_LAT-1] ^ HS_INV;
   assign lcd_vs = vs_sr[DATA_LAT-1] ^ VS_INV;
   assign lcd_r  = rgb_q[15:11];
   assign lcd_g  = rgb_q[10:5];
   assign lcd_b  = rgb_q[4:0];

endmodule
